// File: rtl/dff_rr_arbiter.sv
// Round-robin arbiter that owns one shared WIDTH-bit capture flop; optional DFF_RR_ARBITER_LOCK_EN adds a lock port.
// Latency: the grant is combinational and the winner's data appears on q one clock later.
// Backpressure: a requester holds req/d until it sees gnt at an edge; losers simply wait.
module dff_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] d,
`ifdef DFF_RR_ARBITER_LOCK_EN
  input  logic                     lock,
`endif
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  output logic [IDX_W-1:0]         q_src
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   hi_idx, lo_idx, rr_idx, win_idx;
  logic               hi_hit, rr_hit;
  logic [NUM_REQ-1:0] gnt_c;
  logic               cap;
  logic [WIDTH-1:0]   cap_dat;
`ifdef DFF_RR_ARBITER_LOCK_EN
  logic [IDX_W-1:0]   owner_q, owner_d;
`endif

  // Explicit wrap so non-power-of-2 NUM_REQ never lands on an unused index.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
  endfunction

  // Lowest requester at/above ptr wins; otherwise wrap around to the lowest requester overall.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_hit = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IDX_W'(i);
        if (IDX_W'(i) >= ptr_q) begin
          hi_idx = IDX_W'(i);
          hi_hit = 1'b1;
        end
      end
    end
    rr_hit = |req;
    rr_idx = hi_hit ? hi_idx : lo_idx;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_c   = '0;
    win_idx = rr_idx;
`ifdef DFF_RR_ARBITER_LOCK_EN
    owner_d = owner_q;
`endif
    case (state_q)
`ifdef DFF_RR_ARBITER_LOCK_EN
      LOCKED: begin
        win_idx        = owner_q;
        gnt_c[owner_q] = req[owner_q];
        if (!lock || !req[owner_q]) begin
          state_d = IDLE;
          ptr_d   = next_idx(owner_q);
        end
      end
`endif
      default: begin
        if (rr_hit) begin
          gnt_c[rr_idx] = 1'b1;
`ifdef DFF_RR_ARBITER_LOCK_EN
          if (lock) begin
            state_d = LOCKED;
            owner_d = rr_idx;
          end else
`endif
          ptr_d = next_idx(rr_idx);
        end
      end
    endcase
    // Reset kills the grant immediately, not at the next edge.
    if (!rst_n) begin
      gnt_c = '0;
    end
  end

  assign gnt = gnt_c;
  assign cap = |gnt_c;

  always_comb begin
    cap_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_c[i]) begin
        cap_dat = d[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      q_valid <= 1'b0;
      q_src   <= '0;
      ptr_q   <= '0;
      state_q <= IDLE;
    end else begin
      q_valid <= cap;
      if (cap) begin
        q     <= cap_dat;
        q_src <= win_idx;
      end
      ptr_q   <= ptr_d;
      state_q <= state_d;
    end
  end

`ifdef DFF_RR_ARBITER_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= '0;
    end else begin
      owner_q <= owner_d;
    end
  end
`endif

endmodule

// File: tb/tb_dff_rr_arbiter.sv
// Bench for dff_rr_arbiter: reference model plus directed vectors; lock test when DFF_RR_ARBITER_LOCK_EN is set.
module tb_dff_rr_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   d;
  logic [N-1:0]     gnt;
  logic [W-1:0]     q;
  logic             q_valid;
  logic [1:0]       q_src;
  logic             lock_in;
`ifdef DFF_RR_ARBITER_LOCK_EN
  logic             lock;
  assign lock_in = lock;
`else
  assign lock_in = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dff_rr_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .d       (d),
`ifdef DFF_RR_ARBITER_LOCK_EN
    .lock    (lock),
`endif
    .gnt     (gnt),
    .q       (q),
    .q_valid (q_valid),
    .q_src   (q_src)
  );

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Reference model: pointer, lock owner and last capture as plain integers.
  int         m_ptr    = 0;
  int         m_owner  = 0;
  bit         m_locked = 1'b0;
  logic [W-1:0] m_q    = '0;
  int         m_src    = 0;
  bit         m_vld    = 1'b0;
  int         m_win;
  logic [N-1:0] m_gnt;

  function automatic int winner(input logic [N-1:0] r, input int p, input bit lk, input int own);
    if (lk) return r[own] ? own : -1;
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always_comb m_win = winner(req, m_ptr, m_locked, m_owner);

  always_comb begin
    m_gnt = '0;
    if (rst_n === 1'b1 && m_win >= 0) m_gnt[m_win] = 1'b1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr    <= 0;
      m_owner  <= 0;
      m_locked <= 1'b0;
      m_q      <= '0;
      m_src    <= 0;
      m_vld    <= 1'b0;
    end else begin
      m_vld <= (m_win >= 0);
      if (m_win >= 0) begin
        m_q   <= d[m_win*W +: W];
        m_src <= m_win;
      end
      if (m_locked) begin
        if (!lock_in || !req[m_owner]) begin
          m_locked <= 1'b0;
          m_ptr    <= (m_owner + 1) % N;
        end
      end else if (m_win >= 0) begin
        if (lock_in) begin
          m_locked <= 1'b1;
          m_owner  <= m_win;
        end else begin
          m_ptr <= (m_win + 1) % N;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_gnt",     32'(gnt),     32'(m_gnt));
    chk("cyc_q",       32'(q),       32'(m_q));
    chk("cyc_q_valid", 32'(q_valid), 32'(m_vld));
    chk("cyc_q_src",   32'(q_src),   m_src);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input int i, input logic [W-1:0] v);
    d[i*W +: W] = v;
  endtask

  logic [N-1:0] exp_g [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [W-1:0] exp_q [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11};

  initial begin
    rst_n = 1'b1;
    req   = '0;
    d     = '0;
`ifdef DFF_RR_ARBITER_LOCK_EN
    lock  = 1'b0;
`endif
    #1 rst_n = 1'b0;
    #2;
    chk("rst_gnt",     32'(gnt),     0);
    chk("rst_q",       32'(q),       0);
    chk("rst_q_valid", 32'(q_valid), 0);
    chk("rst_q_src",   32'(q_src),   0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    cyc();

    // Full contention: strict rotation with wrap 3 -> 0.
    for (int i = 0; i < N; i++) set_d(i, 8'h10 + 8'(i));
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1 chk("fc_gnt", 32'(gnt), 32'(exp_g[k]));
      cyc();
      chk("fc_q", 32'(q), 32'(exp_q[k]));
    end

    // Single grant of requester 0 moves ptr to 1.
    req = 4'b0001;
    #1 chk("p1_gnt", 32'(gnt), 32'(4'b0001));
    cyc();

    // Sparse, non-adjacent requesters with ptr=1.
    req = 4'b1001;
    #1 chk("sp_gnt0", 32'(gnt), 32'(4'b1000));
    cyc();
    chk("sp_src", 32'(q_src), 3);
    #1 chk("sp_gnt1", 32'(gnt), 32'(4'b0001));
    cyc();

    // Single continuous requester: back-to-back captures.
    req = 4'b0100;
    set_d(2, 8'hA5);
    for (int k = 0; k < 3; k++) begin
      #1 chk("sg_gnt", 32'(gnt), 32'(4'b0100));
      cyc();
      chk("sg_q",       32'(q),       32'(8'hA5));
      chk("sg_q_src",   32'(q_src),   2);
      chk("sg_q_valid", 32'(q_valid), 1);
    end

    // Capture 3C then idle: q and q_src hold, q_valid drops.
    req = 4'b1000;
    set_d(3, 8'h3C);
    cyc();
    req = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("id_q",       32'(q),       32'(8'h3C));
      chk("id_q_src",   32'(q_src),   3);
      chk("id_q_valid", 32'(q_valid), 0);
    end

    // Reset mid-run with everyone requesting.
    req = 4'b1111;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("mr_gnt",     32'(gnt),     0);
    chk("mr_q",       32'(q),       0);
    chk("mr_q_valid", 32'(q_valid), 0);
    chk("mr_q_src",   32'(q_src),   0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("mr_first_gnt", 32'(gnt), 32'(4'b0001));
    cyc();
    chk("mr_first_q",   32'(q),     32'(8'h10));
    chk("mr_first_src", 32'(q_src), 0);

`ifdef DFF_RR_ARBITER_LOCK_EN
    // Lock requester 1 while everyone requests, then release.
    lock = 1'b1;
    #1 chk("lk_gnt0", 32'(gnt), 32'(4'b0010));
    cyc();
    #1 chk("lk_gnt1", 32'(gnt), 32'(4'b0010));
    cyc();
    lock = 1'b0;
    #1 chk("lk_gnt2", 32'(gnt), 32'(4'b0010));
    cyc();
    #1 chk("lk_after", 32'(gnt), 32'(4'b0100));
    cyc();
`endif

    req = '0;
    cyc();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
